// File: rtl/vector_op_sequencer_if.sv
// Handshake/bus bundle between the vector op sequencer and its environment.
// Carries the command strobe, both BRAM read ports and the UART tx handshake.
// master = sequencer side, slave = decoder/BRAM/UART side.
interface vector_op_sequencer_if #(
  parameter int ADDR_W = 10
);
  logic              cmd_valid;
  logic [2:0]        command;
  logic [7:0]        doutb_A;
  logic              enb_A;
  logic [ADDR_W-1:0] addrb_A;
  logic [7:0]        doutb_B;
  logic              enb_B;
  logic [ADDR_W-1:0] addrb_B;
  logic              tx_ongoing;
  logic              tx_start;
  logic [7:0]        byte_to_send;
  logic              busy;
  logic              done;

  modport master (
    input  cmd_valid, command, doutb_A, doutb_B, tx_ongoing,
    output enb_A, addrb_A, enb_B, addrb_B, tx_start, byte_to_send, busy, done
  );

  modport slave (
    output cmd_valid, command, doutb_A, doutb_B, tx_ongoing,
    input  enb_A, addrb_A, enb_B, addrb_B, tx_start, byte_to_send, busy, done
  );
endinterface

// File: rtl/vector_op_sequencer.sv
// Walks BRAM A/B in lockstep, applies a per-element op and ships each result byte over the UART.
// Latency: 3 cycles FETCH->tx_start minimum per element; element rate is set by the UART handshake.
// Backpressure: SEND holds (no tx_start) while tx_ongoing is high; new commands are dropped while busy.
// Optional MAN_DIST_EN: opcode 6 accumulates |a-b| and sends the 18-bit total as 3 bytes.
module vector_op_sequencer #(
  parameter int VEC_LEN = 1024,
  parameter int ADDR_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  vector_op_sequencer_if.master bus
);

  localparam logic [2:0] OP_READ_A = 3'd1;
  localparam logic [2:0] OP_READ_B = 3'd2;
  localparam logic [2:0] OP_SUM    = 3'd3;
  localparam logic [2:0] OP_AVG    = 3'd4;
  localparam logic [2:0] OP_DIFF   = 3'd5;
`ifdef MAN_DIST_EN
  localparam logic [2:0] OP_MAN    = 3'd6;
`endif

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(VEC_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_COMPUTE,
    S_SEND,
    S_TX_ACK,
    S_TX_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [2:0]        op_q, op_d;
  logic [7:0]        a_q, b_q;
  logic [7:0]        byte_q, byte_d;
  logic              done_q, done_d;
  logic              tx_start_c;
  logic              cmd_ok;

  logic [8:0]        sum9;
  logic [7:0]        diff8;
  logic [7:0]        result;

`ifdef MAN_DIST_EN
  logic [17:0]       acc_q, acc_d;
  logic [1:0]        bsel_q, bsel_d;
  logic [17:0]       acc_sum;
  assign acc_sum = acc_q + {10'd0, diff8};
  assign cmd_ok  = (bus.command >= OP_READ_A) && (bus.command <= OP_MAN);
`else
  assign cmd_ok  = (bus.command >= OP_READ_A) && (bus.command <= OP_DIFF);
`endif

  // Per-element datapath: 9-bit sum feeds both saturation and averaging.
  always_comb begin
    sum9  = {1'b0, a_q} + {1'b0, b_q};
    diff8 = (a_q >= b_q) ? (a_q - b_q) : (b_q - a_q);
    case (op_q)
      OP_READ_A: result = a_q;
      OP_READ_B: result = b_q;
      OP_SUM:    result = sum9[8] ? 8'hFF : sum9[7:0];
      OP_AVG:    result = sum9[8:1];
      OP_DIFF:   result = diff8;
      default:   result = a_q;
    endcase
  end

  // Next-state and handshake decode; every variable defaulted first.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    op_d       = op_q;
    byte_d     = byte_q;
    done_d     = 1'b0;
    tx_start_c = 1'b0;
`ifdef MAN_DIST_EN
    acc_d      = acc_q;
    bsel_d     = bsel_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && cmd_ok) begin
          op_d    = bus.command;
          idx_d   = '0;
          state_d = S_FETCH;
`ifdef MAN_DIST_EN
          acc_d   = '0;
          bsel_d  = 2'd0;
`endif
        end
      end
      S_FETCH:   state_d = S_LATCH;
      S_LATCH:   state_d = S_COMPUTE;
      S_COMPUTE: begin
`ifdef MAN_DIST_EN
        // Distance mode only accumulates; the total leaves after the last element.
        if (op_q == OP_MAN) begin
          acc_d = acc_sum;
          if (idx_q == LAST_IDX) begin
            byte_d  = {6'd0, acc_sum[17:16]};
            state_d = S_SEND;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
        end else
`endif
        begin
          byte_d  = result;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (!bus.tx_ongoing) begin
          tx_start_c = 1'b1;
          state_d    = S_TX_ACK;
        end
      end
      S_TX_ACK: begin
        if (bus.tx_ongoing) state_d = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (!bus.tx_ongoing) begin
`ifdef MAN_DIST_EN
          if (op_q == OP_MAN && bsel_q != 2'd2) begin
            bsel_d  = bsel_q + 2'd1;
            byte_d  = (bsel_q == 2'd0) ? acc_q[15:8] : acc_q[7:0];
            state_d = S_SEND;
          end else
`endif
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, index, opcode and output byte registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      op_q    <= 3'd0;
      byte_q  <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      byte_q  <= byte_d;
      done_q  <= done_d;
    end
  end

  // Operand capture: BRAM data is valid the cycle after FETCH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q <= 8'd0;
      b_q <= 8'd0;
    end else if (state_q == S_LATCH) begin
      a_q <= bus.doutb_A;
      b_q <= bus.doutb_B;
    end
  end

`ifdef MAN_DIST_EN
  // Distance accumulator and result-byte selector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q  <= '0;
      bsel_q <= 2'd0;
    end else begin
      acc_q  <= acc_d;
      bsel_q <= bsel_d;
    end
  end
`endif

  assign bus.enb_A        = (state_q == S_FETCH);
  assign bus.enb_B        = (state_q == S_FETCH);
  assign bus.addrb_A      = idx_q;
  assign bus.addrb_B      = idx_q;
  assign bus.tx_start     = tx_start_c;
  assign bus.byte_to_send = byte_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.done         = done_q;

endmodule

// File: tb/tb_vector_op_sequencer.sv
module tb_vector_op_sequencer;
  localparam int VEC_LEN = 1024;
  localparam int ADDR_W  = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vector_op_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  vector_op_sequencer #(.VEC_LEN(VEC_LEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [7:0] mem_a [VEC_LEN];
  logic [7:0] mem_b [VEC_LEN];

  int   errors = 0;
  int   checks = 0;

  // BRAM models: 1-cycle read latency
  initial begin
    bus.doutb_A = 8'd0;
    bus.doutb_B = 8'd0;
  end
  always @(posedge clk) begin
    if (bus.enb_A) bus.doutb_A <= mem_a[bus.addrb_A];
    if (bus.enb_B) bus.doutb_B <= mem_b[bus.addrb_B];
  end

  // UART model: busy from the cycle after tx_start for tx_len cycles
  int   tx_len = 1;
  int   uart_cnt = 0;
  logic force_busy = 1'b0;
  always @(posedge clk) begin
    if (bus.tx_start) uart_cnt <= tx_len;
    else if (uart_cnt > 0) uart_cnt <= uart_cnt - 1;
  end
  assign bus.tx_ongoing = (uart_cnt > 0) || force_busy;

  // Monitor (single writer of the running totals)
  int         tx_total = 0, fetch_total = 0, done_total = 0;
  int         byte_err = 0, addr_err = 0, stab_err = 0, busy_done_err = 0;
  int         last_addr = -1;
  logic [7:0] held;
  logic [7:0] cap [3];
  int         tx_base = 0, fetch_base = 0;
  bit         exp_idx = 1'b0;
  logic [7:0] exp_byte = 8'd0;

  always @(negedge clk) begin
    int rel;
    int frel;
    logic [7:0] e;
    rel  = tx_total - tx_base;
    frel = fetch_total - fetch_base;
    if (bus.enb_A) begin
      if (!bus.enb_B || bus.addrb_A != ADDR_W'(frel) || bus.addrb_B != ADDR_W'(frel))
        addr_err = addr_err + 1;
      last_addr   = int'(bus.addrb_A);
      fetch_total = fetch_total + 1;
    end
    if (bus.tx_start) begin
      e = exp_idx ? rel[7:0] : exp_byte;
      if (bus.byte_to_send != e) byte_err = byte_err + 1;
      if (rel < 3) cap[rel] = bus.byte_to_send;
      held     = bus.byte_to_send;
      tx_total = tx_total + 1;
    end else if (bus.tx_ongoing && rel > 0 && bus.byte_to_send != held) begin
      stab_err = stab_err + 1;
    end
    if (bus.done) begin
      done_total = done_total + 1;
      if (bus.busy) busy_done_err = busy_done_err + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic send_cmd(input logic [2:0] op);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.command   = op;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.command   = 3'd0;
  endtask

  task automatic wait_done(input int base, input int budget, output bit ok);
    int n;
    n  = 0;
    ok = 1'b1;
    while (done_total == base) begin
      @(negedge clk);
      n = n + 1;
      if (n > budget) begin
        ok = 1'b0;
        break;
      end
    end
  endtask

  typedef struct {
    logic [2:0] op;
    bit         a_idx;
    logic [7:0] a_val;
    logic [7:0] b_val;
    logic [7:0] exp;
    int         tlen;
    bit         inject;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int  db, be, ae, se, bde, fb;
    bit  ok;
    logic [7:0] outs;

    tbl[0] = '{3'd1, 1'b1, 8'h00, 8'h00, 8'h00, 10, 1'b0}; // READ_A, A[i]=i
    tbl[1] = '{3'd2, 1'b0, 8'hA5, 8'h5A, 8'h5A,  1, 1'b0}; // READ_B
    tbl[2] = '{3'd3, 1'b0, 8'hF0, 8'h20, 8'hFF,  1, 1'b1}; // SUM saturates, READ_B injected
    tbl[3] = '{3'd3, 1'b0, 8'h12, 8'h34, 8'h46,  1, 1'b0}; // SUM no carry
    tbl[4] = '{3'd4, 1'b0, 8'hF0, 8'h20, 8'h88,  1, 1'b0}; // AVG uses 9-bit sum
    tbl[5] = '{3'd5, 1'b0, 8'h10, 8'h30, 8'h20,  1, 1'b0}; // DIFF a<b
    tbl[6] = '{3'd5, 1'b0, 8'h35, 8'h10, 8'h25,  1, 1'b0}; // DIFF a>b

    bus.cmd_valid = 1'b0;
    bus.command   = 3'd0;

    // Reset state
    #1;
    check("reset_outputs",
          {bus.enb_A, bus.enb_B, bus.addrb_A, bus.addrb_B, bus.tx_start,
           bus.byte_to_send, bus.busy, bus.done}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Opcodes 0 and 7 in IDLE are ignored
    fb = fetch_total;
    send_cmd(3'd0);
    repeat (5) @(negedge clk);
    check("nop0_busy", bus.busy, 1'b0);
    send_cmd(3'd7);
    repeat (5) @(negedge clk);
    check("nop7_busy", bus.busy, 1'b0);
    check("nop_fetches", fetch_total - fb, 0);

    // Stall at SEND, then reset during TX_WAIT of element 5
    for (int i = 0; i < VEC_LEN; i++) begin
      mem_a[i] = 8'h77;
      mem_b[i] = 8'h00;
    end
    tx_len = 10; exp_idx = 1'b0; exp_byte = 8'h77;
    tx_base = tx_total; fetch_base = fetch_total;
    send_cmd(3'd1);
    check("busy_after_accept", bus.busy, 1'b1);
    check("fetch_first_addr", {bus.enb_A, bus.enb_B, bus.addrb_A}, {2'b11, 10'd0});
    force_busy = 1'b1;
    repeat (50) @(negedge clk);
    check("stall_no_tx_start", tx_total - tx_base, 0);
    check("stall_byte", bus.byte_to_send, 8'h77);
    @(posedge clk);
    #1 force_busy = 1'b0;
    repeat (4) @(negedge clk);
    check("stall_one_pulse", tx_total - tx_base, 1);
    check("stall_byte_after", bus.byte_to_send, 8'h77);
    fb = 0;
    while (tx_total - tx_base < 6 && fb < 500) begin
      @(negedge clk);
      fb = fb + 1;
    end
    check("reach_elem5", tx_total - tx_base, 6);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("midop_reset_outputs",
          {bus.enb_A, bus.enb_B, bus.addrb_A, bus.addrb_B, bus.tx_start,
           bus.byte_to_send, bus.busy, bus.done}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    check("post_reset_no_tx", tx_total - tx_base, 6);
    check("post_reset_no_fetch", fetch_total - fetch_base, 6);
    check("post_reset_idle", bus.busy, 1'b0);

    // Table-driven full-vector runs
    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < VEC_LEN; i++) begin
        mem_a[i] = tbl[t].a_idx ? 8'(i) : tbl[t].a_val;
        mem_b[i] = tbl[t].b_val;
      end
      tx_len = tbl[t].tlen; exp_idx = tbl[t].a_idx; exp_byte = tbl[t].exp;
      tx_base = tx_total; fetch_base = fetch_total;
      db = done_total; be = byte_err; ae = addr_err; se = stab_err; bde = busy_done_err;
      send_cmd(tbl[t].op);
      if (tbl[t].inject) begin
        repeat (30) @(negedge clk);
        send_cmd(3'd2);
      end
      wait_done(db, 40000, ok);
      check($sformatf("run%0d_done_seen", t), ok, 1'b1);
      repeat (3) @(negedge clk);
      check($sformatf("run%0d_tx_count", t), tx_total - tx_base, VEC_LEN);
      check($sformatf("run%0d_byte_errs", t), byte_err - be, 0);
      check($sformatf("run%0d_fetch_count", t), fetch_total - fetch_base, VEC_LEN);
      check($sformatf("run%0d_addr_errs", t), addr_err - ae, 0);
      check($sformatf("run%0d_last_addr", t), last_addr, VEC_LEN - 1);
      check($sformatf("run%0d_done_count", t), done_total - db, 1);
      check($sformatf("run%0d_busy_at_done", t), busy_done_err - bde, 0);
      check($sformatf("run%0d_byte_stable", t), stab_err - se, 0);
      check($sformatf("run%0d_busy_after", t), bus.busy, 1'b0);
    end

    // Opcode 6
    for (int i = 0; i < VEC_LEN; i++) begin
      mem_a[i] = 8'hFF;
      mem_b[i] = 8'h00;
    end
    tx_len = 2; exp_idx = 1'b0; exp_byte = 8'h00;
    tx_base = tx_total; fetch_base = fetch_total; db = done_total;
    send_cmd(3'd6);
`ifdef MAN_DIST_EN
    wait_done(db, 20000, ok);
    check("man_done_seen", ok, 1'b1);
    repeat (3) @(negedge clk);
    check("man_tx_count", tx_total - tx_base, 3);
    check("man_fetch_count", fetch_total - fetch_base, VEC_LEN);
    outs = cap[0]; check("man_byte0", outs, 8'h03);
    outs = cap[1]; check("man_byte1", outs, 8'hFC);
    outs = cap[2]; check("man_byte2", outs, 8'h00);
    check("man_done_count", done_total - db, 1);
    check("man_busy_after", bus.busy, 1'b0);
`else
    repeat (20) @(negedge clk);
    outs = {7'd0, bus.busy};
    check("op6_busy", outs, 8'd0);
    check("op6_no_fetch", fetch_total - fetch_base, 0);
    check("op6_no_tx", tx_total - tx_base, 0);
    check("op6_no_done", done_total - db, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vector_op_sequencer.md
Name: vector_op_sequencer

Overview:
Command-driven sequencer for the coprocessor datapath. It walks BRAM A and BRAM B read ports (port B of each) in lockstep and applies a per-element operation to each pair. Each result byte goes to the UART transmitter through the tx_start/tx_ongoing handshake. It sits between the UART command decoder and the two vector BRAMs, alongside the core's busy/status logic.

Parameters:
VEC_LEN, 1024, number of elements per vector; addresses 0..VEC_LEN-1
ADDR_W, 10, BRAM address width; must satisfy 2**ADDR_W >= VEC_LEN

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
cmd_valid  input  1  one-cycle strobe qualifying command
command  input  3  opcode: 0 NOP, 1 READ_A, 2 READ_B, 3 SUM, 4 AVG, 5 DIFF, 6 MAN, 7 NOP
doutb_A  input  8  BRAM A read data, valid 1 cycle after enb_A/addrb_A
enb_A  output  1  BRAM A read enable
addrb_A  output  ADDR_W  BRAM A read address
doutb_B  input  8  BRAM B read data, 1-cycle latency
enb_B  output  1  BRAM B read enable
addrb_B  output  ADDR_W  BRAM B read address
tx_ongoing  input  1  UART busy; rises the cycle after tx_start and stays high until the byte is out
tx_start  output  1  one-cycle pulse; launches byte_to_send
byte_to_send  output  8  byte to transmit; stable from tx_start until tx_ongoing falls
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the last byte's tx_ongoing falls

Behaviour:
- Reset (rst=0, async):
  - state goes to IDLE and the index counter clears to 0.
  - All outputs are 0: enb_*, addrb_*, tx_start, byte_to_send, busy, done.
  - Reset mid-operation abandons the vector; no further tx_start is issued.
- States: IDLE -> FETCH -> LATCH -> COMPUTE -> SEND -> TX_ACK -> TX_WAIT -> (FETCH | IDLE).
- IDLE:
  - On cmd_valid=1 with opcode 1-6, op is latched, idx=0, next state is FETCH.
  - Opcodes 0/7 are ignored.
  - cmd_valid outside IDLE is ignored; no queuing.
- FETCH:
  - enb_A=enb_B=1 and addrb_A=addrb_B=idx, for 1 cycle.
  - Both enables assert for every opcode.
- LATCH: doutb_A/doutb_B are captured into operand registers a, b.
- COMPUTE: result is registered into byte_to_send:
  - READ_A: a
  - READ_B: b
  - SUM: a+b in 9 bits, saturated to 8'hFF if bit 8 is set
  - AVG: (a+b) >> 1 using the 9-bit sum, no rounding
  - DIFF: |a-b|
- SEND:
  - If tx_ongoing=0, pulse tx_start=1 for exactly 1 cycle and go to TX_ACK.
  - Otherwise stay in SEND without pulsing.
- TX_ACK: wait for tx_ongoing=1.
- TX_WAIT: wait for tx_ongoing=0, then:
  - if idx==VEC_LEN-1: pulse done for 1 cycle and go to IDLE;
  - else idx=idx+1 and go to FETCH.
- idx never wraps. The last address issued is VEC_LEN-1.
- Minimum per-element latency from FETCH to tx_start is 3 cycles (FETCH, LATCH, COMPUTE, then SEND).
- Exactly VEC_LEN bytes are sent per command, in ascending address order.
- busy rises the cycle after the accepted cmd_valid and falls in the same cycle done pulses.

Optional Feature:
Macro: MAN_DIST_EN.
- Defined:
  - Opcode 6 (MAN) accumulates |a-b| over all elements into an 18-bit accumulator. The accumulator is cleared on command accept.
  - No per-element bytes are sent.
  - After the last element, 3 bytes are sent: acc[17:16] zero-extended, then acc[15:8], then acc[7:0]. Each byte uses the same SEND/TX_ACK/TX_WAIT handshake.
  - done pulses after the third byte.
- Not defined: opcode 6 is treated as NOP (ignored in IDLE) and no accumulator exists.

Test Plan:
- Reset mid-operation: rst=0 during TX_WAIT of element 5 -> all outputs 0 immediately; busy=0; after release no tx_start until a new command.
- READ_A, A[i]=i[7:0], tx_ongoing held 10 cycles per byte -> 1024 tx_start pulses with bytes 0x00..0xFF repeated 4 times; addrb_A sequence 0..1023; one done pulse; busy low after.
- SUM with A=0xF0, B=0x20 everywhere -> every byte 0xFF (saturated). AVG on same data -> 0x88. DIFF with A=0x10, B=0x30 -> 0x20.
- Handshake stall: tx_ongoing held high at SEND entry for 50 cycles -> no tx_start until it falls, then exactly one pulse; byte_to_send unchanged across the stall.
- Command while busy: cmd_valid with opcode 2 during a SUM run -> ignored; 1024 SUM bytes only; opcode 0 in IDLE -> busy stays 0.
- MAN_DIST_EN defined, A=0xFF, B=0x00 (VEC_LEN=1024) -> acc=261120=0x3FC00, bytes 0x03, 0xFC, 0x00, then done. Undefined: opcode 6 -> no activity.
